// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator (unsigned or two's-complement), MSB first.
// Optional macro CMP_EARLY_EXIT_EN: finish at the first differing bit instead of after all WIDTH bits.
module serial_mag_cmp #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b
);

   localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             mode_q;
   logic [IDX_W-1:0] idx;

`ifndef CMP_EARLY_EXIT_EN
   // Verdict of the first differing bit, held until bit 0 has been examined.
   logic             found_q;
   logic             found_gt_q;
`endif

   logic bit_diff_c;
   logic bit_gt_c;
   logic last_c;
   logic decide_c;
   logic res_gt_c;
   logic res_eq_c;

   // In signed mode the sign bit has inverted weight, so B's bit wins there.
   always_comb begin
      bit_diff_c = a_q[idx] ^ b_q[idx];
      bit_gt_c   = (mode_q && (idx == MSB_IDX)) ? b_q[idx] : a_q[idx];
      last_c     = (idx == '0);
      decide_c   = 1'b0;
      res_gt_c   = 1'b0;
      res_eq_c   = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
      if (bit_diff_c) begin
         decide_c = 1'b1;
         res_gt_c = bit_gt_c;
      end else if (last_c) begin
         decide_c = 1'b1;
         res_eq_c = 1'b1;
      end
`else
      if (last_c) begin
         decide_c = 1'b1;
         if (found_q) begin
            res_gt_c = found_gt_q;
         end else if (bit_diff_c) begin
            res_gt_c = bit_gt_c;
         end else begin
            res_eq_c = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= 1'b0;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         a_gt_b <= 1'b0;
         a_eq_b <= 1'b0;
         a_lt_b <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
         found_q    <= 1'b0;
         found_gt_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  mode_q <= signed_mode;
                  idx    <= MSB_IDX;
                  busy   <= 1'b1;
                  state  <= RUN;
`ifndef CMP_EARLY_EXIT_EN
                  found_q    <= 1'b0;
                  found_gt_q <= 1'b0;
`endif
               end
            end
            RUN: begin
`ifndef CMP_EARLY_EXIT_EN
               if (!found_q && bit_diff_c) begin
                  found_q    <= 1'b1;
                  found_gt_q <= bit_gt_c;
               end
`endif
               if (decide_c) begin
                  a_gt_b <= res_gt_c;
                  a_eq_b <= res_eq_c;
                  a_lt_b <= !res_gt_c && !res_eq_c;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx - IDX_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Randomized and directed bench for serial_mag_cmp (WIDTH=8) against an arithmetic reference model.
module tb_serial_mag_cmp;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         signed_mode;
   logic         busy;
   logic         done;
   logic         a_gt_b;
   logic         a_eq_b;
   logic         a_lt_b;

   int n_checks;
   int n_errors;
   logic [2:0] prev_res;

   serial_mag_cmp #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .a_gt_b      (a_gt_b),
      .a_eq_b      (a_eq_b),
      .a_lt_b      (a_lt_b)
   );

   always #5 clk = ~clk;

   // Expected {gt, eq, lt} from plain integer comparison.
   function automatic logic [2:0] model_res(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm);
      int va;
      int vb;
      if (tm) begin
         va = int'($signed(ta));
         vb = int'($signed(tb));
      end else begin
         va = int'({24'd0, ta});
         vb = int'({24'd0, tb});
      end
      if (va > vb) return 3'b100;
      if (va == vb) return 3'b010;
      return 3'b001;
   endfunction

   // Edges from the accepting edge to the deciding edge.
   function automatic int model_lat(input logic [W-1:0] ta, input logic [W-1:0] tb);
      int lat;
      lat = W;
`ifdef CMP_EARLY_EXIT_EN
      for (int i = 0; i < W; i++) begin
         if (ta[i] != tb[i]) lat = W - i;
      end
`endif
      return lat;
   endfunction

   // One comparison; poke keeps start asserted with a=0 while busy and through DONE.
   task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm, input bit poke, input string name);
      logic [2:0] exp_res;
      int exp_lat;
      int lat;
      bit got;
      exp_res = model_res(ta, tb, tm);
      exp_lat = model_lat(ta, tb);
      start = 1'b1;
      a = ta;
      b = tb;
      signed_mode = tm;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL %s accept: busy=%b done=%b, expected busy=1 done=0", name, busy, done);
      end
      start = poke;
      got = 0;
      lat = 0;
      for (int k = 1; k <= W + 4 && !got; k++) begin
         a = poke ? '0 : W'($urandom);
         b = W'($urandom);
         signed_mode = 1'($urandom);
         @(posedge clk); #1;
         if (done === 1'b1) begin
            got = 1;
            lat = k;
         end else begin
            n_checks++;
            if (busy !== 1'b1 || {a_gt_b, a_eq_b, a_lt_b} !== prev_res) begin
               n_errors++;
               $display("FAIL %s hold@%0d: busy=%b res=%b, expected busy=1 res=%b", name, k, busy, {a_gt_b, a_eq_b, a_lt_b}, prev_res);
            end
         end
      end
      n_checks++;
      if (!got) begin
         n_errors++;
         $display("FAIL %s timeout: no done within %0d edges, expected at %0d", name, W + 4, exp_lat);
      end else if (lat != exp_lat) begin
         n_errors++;
         $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
      end
      n_checks++;
      if ({a_gt_b, a_eq_b, a_lt_b} !== exp_res || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL %s result: res=%b busy=%b, expected res=%b busy=0", name, {a_gt_b, a_eq_b, a_lt_b}, busy, exp_res);
      end
      prev_res = exp_res;
      if (!poke) start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || {a_gt_b, a_eq_b, a_lt_b} !== prev_res) begin
         n_errors++;
         $display("FAIL %s pulse: done=%b res=%b, expected done=0 res=%b", name, done, {a_gt_b, a_eq_b, a_lt_b}, prev_res);
      end
      if (poke) begin
         start = 1'b0;
         @(posedge clk); #1;
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s ignore: busy=%b done=%b, expected 0 0", name, busy, done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      a = 8'h12;
      b = 8'h34;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset: outs=%b, expected 00000", {busy, done, a_gt_b, a_eq_b, a_lt_b});
      end
      start = 1'b0;
      rst = 1'b0;
      prev_res = 3'b000;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      run_cmp(8'hA5, 8'hA5, 1'b0, 0, "eq_a5");
      run_cmp(8'h80, 8'h7F, 1'b0, 0, "ugt_80_7f");
      run_cmp(8'h80, 8'h7F, 1'b1, 0, "slt_80_7f");
      run_cmp(8'hFF, 8'hFE, 1'b1, 0, "sgt_ff_fe");
      run_cmp(8'h12, 8'h13, 1'b0, 1, "lt_busy_poke");
   endtask

   task automatic test_abort();
      bit seen;
      start = 1'b1;
      a = 8'h5A;
      b = 8'h5A;
      signed_mode = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b} !== 5'b0) begin
         n_errors++;
         $display("FAIL abort: outs=%b, expected 00000", {busy, done, a_gt_b, a_eq_b, a_lt_b});
      end
      prev_res = 3'b000;
      seen = 0;
      for (int k = 0; k < W + 2; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen = 1;
      end
      n_checks++;
      if (seen) begin
         n_errors++;
         $display("FAIL abort_quiet: done/busy seen=%b after reset, expected 0", seen);
      end
      run_cmp(8'h3C, 8'hC3, 1'b1, 0, "after_abort");
   endtask

   task automatic test_back_to_back();
      run_cmp(8'h40, 8'h41, 1'b0, 0, "b2b_first");
      run_cmp(8'h9C, 8'h1C, 1'b1, 0, "b2b_second");
      run_cmp(8'h9C, 8'h1C, 1'b0, 0, "b2b_third");
   endtask

   task automatic test_random();
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      for (int n = 0; n < 60; n++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
         run_cmp(ra, rb, 1'($urandom), bit'($urandom_range(0, 4) == 0), "random");
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      signed_mode = 1'b0;
      n_checks = 0;
      n_errors = 0;
      prev_res = 3'b000;
      #2;
      test_reset();
      test_directed();
      test_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_mag_cmp.md
SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on accepted start.
REQ-007 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
REQ-008 SHALL have port busy  output  1  comparison in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-010 SHALL have port a_gt_b  output  1  registered result, A > B.
REQ-011 SHALL have port a_eq_b  output  1  registered result, A == B.
REQ-012 SHALL have port a_lt_b  output  1  registered result, A < B.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL, in IDLE with start=1 at edge E0: capture a, b and signed_mode, load bit index WIDTH-1, enter RUN; busy=1 after E0.
REQ-015 SHALL, in RUN, examine exactly one bit pair per edge, MSB first, decrementing the index.
REQ-016 SHALL decide on the first differing bit i: unsigned gives gt if a[i]=1; signed gives the inverse of that when i = WIDTH-1, otherwise as unsigned.
REQ-017 SHALL decide eq when bit 0 has been examined with no difference found.
REQ-018 SHALL, on the deciding edge, register results (exactly one of gt/eq/lt = 1), clear busy and enter DONE.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-020 SHALL hold a_gt_b, a_eq_b and a_lt_b stable from the deciding edge until the next deciding edge or reset; they SHALL NOT clear on a new start.
REQ-021 SHALL ignore start while in RUN or DONE; operands and mode SHALL NOT change mid-comparison.
REQ-022 SHALL accept a start asserted in the IDLE cycle that immediately follows DONE (back-to-back throughput).
REQ-023 SHALL ignore changes on a, b and signed_mode outside the accepting edge.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, force state IDLE and busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0, bit index 0.
REQ-025 SHALL abort any comparison in progress on reset, with no done pulse.
REQ-026 SHALL give rst priority over start when both are asserted at the same edge.

Configuration
REQ-027 SHALL support macro CMP_EARLY_EXIT_EN.
REQ-028 SHALL, with CMP_EARLY_EXIT_EN defined, decide at the first differing bit; latency from E0 to the deciding edge = WIDTH-i edges for first difference at bit i, and WIDTH edges for eq.
REQ-029 SHALL, without CMP_EARLY_EXIT_EN, always examine all WIDTH bits; the decision is latched internally at the first difference; the deciding edge is always E0+WIDTH (constant latency); results are identical to the defined case.

Verification (WIDTH=8)
REQ-030 SHALL cover: unsigned compare, a=0xA5, b=0xA5 -> a_eq_b=1, done pulse in the cycle after E0+8, in both configurations.
REQ-031 SHALL cover: unsigned compare, a=0x80, b=0x7F -> a_gt_b=1; with CMP_EARLY_EXIT_EN, done in the cycle after E0+1; without it, done in the cycle after E0+8.
REQ-032 SHALL cover: signed compare, a=0x80, b=0x7F -> a_lt_b=1; and signed compare, a=0xFF, b=0xFE -> a_gt_b=1.
REQ-033 SHALL cover: a=0x12, b=0x13 -> a_lt_b=1, done in the cycle after E0+8; start pulsed with a=0x00 while busy -> ignored, result unchanged.
REQ-034 SHALL cover: rst=1 at E0+3 of a run -> busy=0, all results 0, no done pulse; a following start completes normally.
REQ-035 SHALL cover: back-to-back starts, the second in the IDLE cycle right after done -> both complete with correct results; the first result holds until the second deciding edge.
